// File: rtl/usrt_trn.sv
// usrt_trn: FIFO-buffered synchronous serial transmitter.
// Each byte goes out as a 10-bit frame (start, 8 data LSB first, stop) alongside a self-generated serial clock.
module usrt_trn #(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_BITS   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          usrt_clk,
  output logic                          usrt_tx
);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;
  localparam int GAP_CLKS = 2 * CLK_DIV * GAP_BITS;
  localparam int CNT_MAX  = GAP_CLKS > CLK_DIV ? GAP_CLKS : CLK_DIV;
  localparam int CW       = $clog2(CNT_MAX + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    sr_q, sr_d;
  logic          full_q, empty_q, ovf_q, ovf_d, busy_q, done_q;
  logic          uclk_q, uclk_d, tx_q, tx_d;
  logic          push, pop, tc;
  always_comb begin
    push    = wr_en && !full_q;
    pop     = state_q == IDLE && !empty_q;
    tc      = cnt_q == CW'(CLK_DIV - 1);
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    level_d = level_q + LW'(push) - LW'(pop);
    // full is judged before any same-cycle pop, so a write while full is always lost
    ovf_d   = ovf_q || (wr_en && full_q);
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    uclk_d  = uclk_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = SHIFT;
        sr_d    = {1'b1, mem_q[rptr_q], 1'b0};
        cnt_d   = '0;
        bit_d   = '0;
        uclk_d  = 1'b0;
        tx_d    = 1'b0;
      end
      SHIFT: begin
        cnt_d = tc ? '0 : cnt_q + 1'b1;
        if (tc && !uclk_q) uclk_d = 1'b1;
        else if (tc && bit_q != 4'd9) begin
          bit_d  = bit_q + 4'd1;
          sr_d   = sr_q >> 1;
          tx_d   = sr_q[1];
          uclk_d = 1'b0;
        end else if (tc) state_d = GAP_BITS == 0 ? DONE : GAP;
      end
      GAP: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(GAP_CLKS - 1) ? DONE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      uclk_q  <= 1'b1;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      full_q  <= level_d == LW'(FIFO_DEPTH);
      empty_q <= level_d == '0;
      ovf_q   <= ovf_d;
      busy_q  <= state_d != IDLE || level_d != '0;
      done_q  <= state_d == DONE;
      uclk_q  <= uclk_d;
      tx_q    <= tx_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wptr_q] <= wr_data;
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;
  assign usrt_clk = uclk_q;
  assign usrt_tx  = tx_q;
endmodule

// File: tb/tb_usrt_trn.sv
// tb_usrt_trn: scoreboard bench for two usrt_trn instances (CLK_DIV=4/GAP=1 and CLK_DIV=1/GAP=0).
module tb_usrt_trn;
  logic clk, rst;
  logic wr0, wr1;
  logic [7:0] d0, d1;
  logic full0, empty0, ovf0, busy0, done0, uclk0, tx0;
  logic full1, empty1, ovf1, busy1, done1, uclk1, tx1;
  logic [2:0] level0, level1;
  logic [1:0] uc, ut, dn, prev;
  int n_cmp = 0, n_fail = 0, cyc = 0;
  int run [2], nb [2], t0 [2], fc [2];
  logic [9:0] sh [2];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] e;
  logic has;
  int t;

  usrt_trn #(.CLK_DIV(4), .FIFO_DEPTH(4), .GAP_BITS(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr0), .wr_data(d0), .full(full0), .empty(empty0),
    .level(level0), .overflow(ovf0), .busy(busy0), .tx_done(done0),
    .usrt_clk(uclk0), .usrt_tx(tx0));
  usrt_trn #(.CLK_DIV(1), .FIFO_DEPTH(4), .GAP_BITS(0)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr1), .wr_data(d1), .full(full1), .empty(empty1),
    .level(level1), .overflow(ovf1), .busy(busy1), .tx_done(done1),
    .usrt_clk(uclk1), .usrt_tx(tx1));

  assign uc = {uclk1, uclk0};
  assign ut = {tx1, tx0};
  assign dn = {done1, done0};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int k, input int lim);
    int i = 0;
    do begin
      tick();
      i++;
    end while (!dn[k] && i < lim);
    chk("tx_done_seen", int'(dn[k]), 1);
  endtask

  task automatic push0(input logic [7:0] b, input bit expect_tx);
    wr0 = 1'b1;
    d0 = b;
    if (expect_tx) q0.push_back(b);
    tick();
    wr0 = 1'b0;
    d0 = 8'hxx;
  endtask

  // Monitor: rebuilds frames from the serial lines and checks them against the expected queues
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        nb[k] = 0;
        run[k] = 0;
        prev[k] = 1'b1;
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        if (uc[k] != prev[k]) begin
          if (!prev[k] || nb[k] > 0) chk("phase_len", run[k], k == 0 ? 4 : 1);
          if (!uc[k]) begin
            fc[k]++;
            if (nb[k] == 0) t0[k] = cyc;
          end else begin
            sh[k] = {ut[k], sh[k][9:1]};
            nb[k]++;
            if (nb[k] == 10) begin
              chk("start_bit", int'(sh[k][0]), 0);
              chk("stop_bit", int'(sh[k][9]), 1);
              has = 1'b0;
              e = 8'h00;
              if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); has = 1'b1; end
              if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); has = 1'b1; end
              chk("frame_expected", int'(has), 1);
              chk("frame_byte", int'(sh[k][8:1]), int'(e));
            end
          end
          run[k] = 1;
        end else run[k]++;
        if (dn[k]) begin
          chk("done_after_frame", nb[k], 10);
          chk("done_latency", cyc - t0[k], k == 0 ? 88 : 20);
          nb[k] = 0;
        end
        prev[k] = uc[k];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    fc[0] = 0; fc[1] = 0;
    rst = 1'b1; wr0 = 1'b0; wr1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_level", int'(level0), 0);
    chk("rst_empty", int'(empty0), 1);
    chk("rst_full", int'(full0), 0);
    chk("rst_overflow", int'(ovf0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_tx_done", int'(done0), 0);
    chk("rst_usrt_clk", int'(uclk0), 1);
    chk("rst_usrt_tx", int'(tx0), 1);
    // single frame 0xA5
    push0(8'hA5, 1'b1);
    chk("busy_after_push", int'(busy0), 1);
    wait_done(0, 200);
    tick();
    chk("idle_busy", int'(busy0), 0);
    chk("idle_usrt_clk", int'(uclk0), 1);
    chk("idle_usrt_tx", int'(tx0), 1);
    // five back-to-back pushes fill the FIFO; the sixth is dropped
    for (int i = 1; i <= 5; i++) push0(8'(i), 1'b1);
    chk("fill_full", int'(full0), 1);
    chk("fill_level", int'(level0), 4);
    chk("fill_ovf_clear", int'(ovf0), 0);
    push0(8'h06, 1'b0);
    chk("drop_overflow", int'(ovf0), 1);
    chk("drop_level", int'(level0), 4);
    for (int i = 0; i < 5; i++) begin
      wait_done(0, 200);
      chk("level_step", int'(level0), 4 - i);
    end
    repeat (3) tick();
    // reset in the middle of frame 0x3C with two bytes queued
    push0(8'h3C, 1'b1);
    push0(8'hA1, 1'b1);
    push0(8'hA2, 1'b1);
    chk("queued_level", int'(level0), 2);
    repeat (33) tick();
    chk("mid_frame_busy", int'(busy0), 1);
    rst = 1'b1;
    #1;
    chk("async_rst_usrt_clk", int'(uclk0), 1);
    chk("async_rst_usrt_tx", int'(tx0), 1);
    chk("async_rst_level", int'(level0), 0);
    chk("async_rst_overflow", int'(ovf0), 0);
    tick();
    rst = 1'b0;
    t = fc[0];
    repeat (40) tick();
    chk("no_edges_after_rst", fc[0], t);
    chk("no_done_after_rst", int'(busy0), 0);
    // write while full coinciding with a pop
    for (int i = 0; i < 5; i++) push0(8'h11 + 8'(i), 1'b1);
    wait_done(0, 200);
    chk("coll_level_before", int'(level0), 4);
    chk("coll_full_before", int'(full0), 1);
    tick();
    push0(8'h99, 1'b0);
    chk("coll_overflow", int'(ovf0), 1);
    chk("coll_level_after", int'(level0), 3);
    chk("coll_full_after", int'(full0), 0);
    for (int i = 0; i < 4; i++) wait_done(0, 200);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    // pointer wrap: ten frames, one at a time
    for (int i = 0; i < 10; i++) begin
      push0(8'(i * 37 + 5), 1'b1);
      chk("wrap_level", int'(level0), 1);
      wait_done(0, 200);
    end
    chk("wrap_overflow", int'(ovf0), 0);
    // fast instance: 0x00 then 0xFF back to back
    wr1 = 1'b1; d1 = 8'h00; q1.push_back(8'h00);
    tick();
    d1 = 8'hFF; q1.push_back(8'hFF);
    tick();
    wr1 = 1'b0;
    wait_done(1, 100);
    t = cyc;
    wait_done(1, 100);
    chk("fast_done_spacing", cyc - t, 22);
    chk("fast_overflow", int'(ovf1), 0);
    repeat (5) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
